// File: rtl/dds_phase_accumulator_if.sv
// Configuration port of the DDS phase accumulator: tuning word, phase offset
// and apply-mode, transferred on cfg_valid & cfg_ready.
interface dds_phase_accumulator_if #(
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned ROM_ADDR_WIDTH = 12
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [ACC_WIDTH-1:0]      cfg_ftw;
  logic [ROM_ADDR_WIDTH-1:0] cfg_poff;
  logic                      cfg_sync;

  modport master (
    output cfg_valid, cfg_ftw, cfg_poff, cfg_sync,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ftw, cfg_poff, cfg_sync,
    output cfg_ready
  );
endinterface

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: integrates the FTW, adds a phase offset and truncates to a
// ROM address. Optional LFSR phase dither below the truncation point: DDS_PHASE_DITHER_EN.
module dds_phase_accumulator #(
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned ROM_ADDR_WIDTH = 12,
  parameter int unsigned DITHER_BITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      sync_clr,
  dds_phase_accumulator_if.slave    cfg,
  output logic [ROM_ADDR_WIDTH-1:0] addr,
  output logic                      addr_valid,
  output logic                      wrap
);

  localparam int unsigned FRAC_BITS = ACC_WIDTH - ROM_ADDR_WIDTH;

  if (DITHER_BITS >= FRAC_BITS) begin : g_bad_dither
    $error("DITHER_BITS must be smaller than ACC_WIDTH-ROM_ADDR_WIDTH");
  end

  typedef enum logic [0:0] {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t                    state;
  logic [ACC_WIDTH-1:0]      acc;
  logic [ACC_WIDTH-1:0]      ftw_act;
  logic [ROM_ADDR_WIDTH-1:0] poff_act;
  logic [ACC_WIDTH-1:0]      shadow_ftw;
  logic [ROM_ADDR_WIDTH-1:0] shadow_poff;

  logic [ACC_WIDTH:0]        sum_c;
  logic                      carry_c;
  logic                      xfer_c;
  logic [ROM_ADDR_WIDTH-1:0] phase_c;

  assign sum_c   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry_c = sum_c[ACC_WIDTH];
  assign xfer_c  = cfg.cfg_valid & cfg.cfg_ready;

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0]          lfsr;
  logic [ACC_WIDTH-1:0] dithered_c;

  // Fibonacci LFSR, taps 16,14,13,11; only steps when a new address is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (ce && !sync_clr) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign dithered_c = acc + (ACC_WIDTH'(lfsr[DITHER_BITS-1:0]) << (FRAC_BITS - DITHER_BITS));
  assign phase_c    = dithered_c[ACC_WIDTH-1 -: ROM_ADDR_WIDTH];
`else
  assign phase_c    = acc[ACC_WIDTH-1 -: ROM_ADDR_WIDTH];
`endif

  // Accumulator, config apply FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cfg.cfg_ready <= 1'b1;
      acc           <= '0;
      ftw_act       <= '0;
      poff_act      <= '0;
      shadow_ftw    <= '0;
      shadow_poff   <= '0;
      addr          <= '0;
      addr_valid    <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (sync_clr) begin
        // Clear forces any pending update in; a same-cycle transfer wins and applies now
        acc <= '0;
        if (state == PEND) begin
          ftw_act  <= shadow_ftw;
          poff_act <= shadow_poff;
        end
        if (xfer_c) begin
          ftw_act  <= cfg.cfg_ftw;
          poff_act <= cfg.cfg_poff;
        end
        state         <= RUN;
        cfg.cfg_ready <= 1'b1;
      end else begin
        if (ce) begin
          acc        <= sum_c[ACC_WIDTH-1:0];
          addr       <= phase_c + poff_act;
          addr_valid <= 1'b1;
          wrap       <= carry_c;
        end
        case (state)
          RUN: begin
            if (xfer_c) begin
              if (cfg.cfg_sync) begin
                shadow_ftw    <= cfg.cfg_ftw;
                shadow_poff   <= cfg.cfg_poff;
                state         <= PEND;
                cfg.cfg_ready <= 1'b0;
              end else begin
                ftw_act  <= cfg.cfg_ftw;
                poff_act <= cfg.cfg_poff;
              end
            end
          end
          PEND: begin
            // Phase-synchronous apply at the wrap edge; this edge still used the old FTW
            if (ce && carry_c) begin
              ftw_act       <= shadow_ftw;
              poff_act      <= shadow_poff;
              state         <= RUN;
              cfg.cfg_ready <= 1'b1;
            end
          end
          default: begin
            state         <= RUN;
            cfg.cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Bench for dds_phase_accumulator: directed scenarios plus randomized traffic
// checked against a cycle-level arithmetic model of the phase accumulator.
module tb_dds_phase_accumulator;

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 12;
  localparam int unsigned DB = 4;
  localparam logic [AW-1:0] PHASE_STEP = AW'(1) << (AW - RW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic sync_clr = 1'b0;
  logic [RW-1:0] addr;
  logic addr_valid;
  logic wrap;

  int n_cmp = 0;
  int n_bad = 0;

  dds_phase_accumulator_if #(.ACC_WIDTH(AW), .ROM_ADDR_WIDTH(RW)) cfg_bus ();

  dds_phase_accumulator #(.ACC_WIDTH(AW), .ROM_ADDR_WIDTH(RW), .DITHER_BITS(DB)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync_clr(sync_clr), .cfg(cfg_bus),
    .addr(addr), .addr_valid(addr_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [AW-1:0] m_acc, m_ftw, m_sh_ftw;
  logic [RW-1:0] m_poff, m_sh_poff, m_addr;
  logic m_pend, m_valid, m_wrap;

  function automatic void model_reset();
    m_acc = '0; m_ftw = '0; m_sh_ftw = '0;
    m_poff = '0; m_sh_poff = '0; m_addr = '0;
    m_pend = 1'b0; m_valid = 1'b0; m_wrap = 1'b0;
  endfunction

  // One clock of the specified behaviour, using the inputs currently driven
  function automatic void model_step();
    logic [AW:0] total;
    logic carry, xfer;
    xfer  = cfg_bus.cfg_valid && !m_pend;
    total = {1'b0, m_acc} + {1'b0, m_ftw};
    carry = (total >= (33'd1 << AW));
    if (sync_clr) begin
      m_acc = '0; m_wrap = 1'b0;
      if (m_pend) begin m_ftw = m_sh_ftw; m_poff = m_sh_poff; m_pend = 1'b0; end
      if (xfer) begin m_ftw = cfg_bus.cfg_ftw; m_poff = cfg_bus.cfg_poff; end
    end else begin
      m_wrap = ce && carry;
      if (ce) begin
        m_addr  = RW'(m_acc / PHASE_STEP) + m_poff;
        m_acc   = AW'(total % (33'd1 << AW));
        m_valid = 1'b1;
      end
      if (m_pend) begin
        if (ce && carry) begin m_ftw = m_sh_ftw; m_poff = m_sh_poff; m_pend = 1'b0; end
      end else if (xfer) begin
        if (cfg_bus.cfg_sync) begin m_sh_ftw = cfg_bus.cfg_ftw; m_sh_poff = cfg_bus.cfg_poff; m_pend = 1'b1; end
        else begin m_ftw = cfg_bus.cfg_ftw; m_poff = cfg_bus.cfg_poff; end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic v, input logic [AW-1:0] f, input logic [RW-1:0] p, input logic s);
    cfg_bus.cfg_valid = v; cfg_bus.cfg_ftw = f; cfg_bus.cfg_poff = p; cfg_bus.cfg_sync = s;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", addr); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", addr_valid); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cfg_bus.cfg_ready); end
    rst = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL idle_addr cyc %0d got %0h want 0", i, addr); end
      n_cmp++; if (addr_valid !== 1'b1) begin n_bad++; $display("FAIL idle_valid cyc %0d got %b want 1", i, addr_valid); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL idle_wrap cyc %0d got %b want 0", i, wrap); end
      n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready cyc %0d got %b want 1", i, cfg_bus.cfg_ready); end
    end
  endtask

  task automatic test_ramp();
    int wraps = 0;
    logic [RW-1:0] exp_addr;
    ce = 1'b0;
    drive_cfg(1'b1, 32'h0010_0000, '0, 1'b0);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    ce = 1'b1;
    for (int k = 1; k <= 4097; k++) begin
      tick();
      exp_addr = RW'((k - 1) % 4096);
      n_cmp++; if (addr !== exp_addr) begin n_bad++; $display("FAIL ramp_addr k=%0d got %0d want %0d", k, addr, exp_addr); end
      n_cmp++; if (wrap !== (k == 4096)) begin n_bad++; $display("FAIL ramp_wrap k=%0d got %b want %b", k, wrap, k == 4096); end
      if (wrap === 1'b1) wraps++;
    end
    n_cmp++; if (wraps != 1) begin n_bad++; $display("FAIL ramp_wrap_count got %0d want 1", wraps); end
  endtask

  task automatic test_poff_immediate();
    logic [RW-1:0] prev;
    ce = 1'b0;
    prev = addr;
    drive_cfg(1'b1, 32'h0010_0000, 12'h400, 1'b0);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    n_cmp++; if (addr !== prev) begin n_bad++; $display("FAIL poff_hold got %0h want %0h", addr, prev); end
    ce = 1'b1;
    tick();
    n_cmp++; if (addr !== RW'(prev + 1 + 1024)) begin n_bad++; $display("FAIL poff_jump got %0h want %0h", addr, RW'(prev + 1 + 1024)); end
    for (int i = 0; i < 5; i++) begin
      prev = addr;
      tick();
      n_cmp++; if (addr !== RW'(prev + 1)) begin n_bad++; $display("FAIL poff_step %0d got %0h want %0h", i, addr, RW'(prev + 1)); end
    end
  endtask

  task automatic test_sync_apply();
    logic [RW-1:0] prev;
    bit seen = 1'b0;
    ce = 1'b1;
    drive_cfg(1'b1, 32'h0020_0000, 12'h400, 1'b1);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL sync_ready_drop got %b want 0", cfg_bus.cfg_ready); end
    for (int i = 0; i < 5000 && !seen; i++) begin
      prev = addr;
      tick();
      n_cmp++; if (addr !== RW'(prev + 1)) begin n_bad++; $display("FAIL sync_pre_step %0d got %0h want %0h", i, addr, RW'(prev + 1)); end
      n_cmp++; if (cfg_bus.cfg_ready !== wrap) begin n_bad++; $display("FAIL sync_ready %0d got %b want %b", i, cfg_bus.cfg_ready, wrap); end
      if (wrap === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL sync_wrap_timeout got none want wrap"); end
    prev = addr;
    tick();
    n_cmp++; if (addr !== RW'(prev + 1)) begin n_bad++; $display("FAIL sync_wrap_step got %0h want %0h", addr, RW'(prev + 1)); end
    for (int i = 0; i < 4; i++) begin
      prev = addr;
      tick();
      n_cmp++; if (addr !== RW'(prev + 2)) begin n_bad++; $display("FAIL sync_post_step %0d got %0h want %0h", i, addr, RW'(prev + 2)); end
    end
  endtask

  task automatic test_ce_toggle();
    logic [RW-1:0] prev;
    ce = 1'b0;
    drive_cfg(1'b1, 32'h0010_0000, '0, 1'b0);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    ce = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      prev = addr;
      tick();
      if (ce) begin
        n_cmp++; if (addr !== RW'(prev + 1)) begin n_bad++; $display("FAIL toggle_adv %0d got %0h want %0h", i, addr, RW'(prev + 1)); end
      end else begin
        n_cmp++; if (addr !== prev) begin n_bad++; $display("FAIL toggle_hold %0d got %0h want %0h", i, addr, prev); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL toggle_wrap %0d got %b want 0", i, wrap); end
      end
    end
  endtask

  task automatic test_pend_sync_clr();
    logic [RW-1:0] prev;
    ce = 1'b0;
    drive_cfg(1'b1, '0, '0, 1'b0);
    tick();
    drive_cfg(1'b1, 32'h0030_0000, 12'd5, 1'b1);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    ce = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL pend_stuck_ready %0d got %b want 0", i, cfg_bus.cfg_ready); end
    end
    prev = addr;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready got %b want 1", cfg_bus.cfg_ready); end
    n_cmp++; if (addr !== prev) begin n_bad++; $display("FAIL clr_addr_hold got %0h want %0h", addr, prev); end
    tick();
    n_cmp++; if (addr !== 12'd5) begin n_bad++; $display("FAIL clr_first got %0d want 5", addr); end
    tick();
    n_cmp++; if (addr !== 12'd8) begin n_bad++; $display("FAIL clr_second got %0d want 8", addr); end
    // Clear and a deferred-mode transfer together: transfer applies at once
    ce = 1'b0;
    sync_clr = 1'b1;
    drive_cfg(1'b1, 32'h0010_0000, '0, 1'b1);
    tick();
    sync_clr = 1'b0;
    drive_cfg(1'b0, '0, '0, 1'b0);
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clr_xfer_ready got %b want 1", cfg_bus.cfg_ready); end
    ce = 1'b1;
    tick();
    n_cmp++; if (addr !== 12'd0) begin n_bad++; $display("FAIL clr_xfer_first got %0d want 0", addr); end
    tick();
    n_cmp++; if (addr !== 12'd1) begin n_bad++; $display("FAIL clr_xfer_second got %0d want 1", addr); end
  endtask

  task automatic test_rst_pend();
    ce = 1'b0;
    drive_cfg(1'b1, '0, '0, 1'b0);
    tick();
    drive_cfg(1'b1, 32'h0040_0000, 12'h123, 1'b1);
    tick();
    drive_cfg(1'b0, '0, '0, 1'b0);
    ce = 1'b1;
    repeat (3) tick();
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rstp_pend_ready got %b want 0", cfg_bus.cfg_ready); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL rstp_addr got %0h want 0", addr); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_bad++; $display("FAIL rstp_valid got %b want 0", addr_valid); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL rstp_wrap got %b want 0", wrap); end
    n_cmp++; if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready got %b want 1", cfg_bus.cfg_ready); end
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL rstp_noapply %0d got %0h want 0", i, addr); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      ce       = ($urandom % 4) != 0;
      sync_clr = ($urandom % 64) == 0;
      drive_cfg(($urandom % 8) == 0, ($urandom % 16 == 0) ? '0 : AW'($urandom),
                RW'($urandom), 1'($urandom % 2));
      tick();
      n_cmp++; if (addr !== m_addr) begin n_bad++; $display("FAIL rand_addr %0d got %0h want %0h", i, addr, m_addr); end
      n_cmp++; if (addr_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid %0d got %b want %b", i, addr_valid, m_valid); end
      n_cmp++; if (wrap !== m_wrap) begin n_bad++; $display("FAIL rand_wrap %0d got %b want %b", i, wrap, m_wrap); end
      n_cmp++; if (cfg_bus.cfg_ready !== !m_pend) begin n_bad++; $display("FAIL rand_ready %0d got %b want %b", i, cfg_bus.cfg_ready, !m_pend); end
    end
    ce = 1'b0; sync_clr = 1'b0;
    drive_cfg(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    drive_cfg(1'b0, '0, '0, 1'b0);
    model_reset();
    test_reset();
    test_ramp();
    test_poff_immediate();
    test_sync_apply();
    test_ce_toggle();
    test_pend_sync_clr();
    test_rst_pend();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
